// File: rtl/vga_pkg.sv
// Shared VGA timing constants and state encoding for the capture path.
// The display controller uses the same constants, so both ends stay in step.
package vga_pkg;

    localparam int unsigned H_TOTAL     = 800;
    localparam int unsigned V_TOTAL     = 525;
    localparam int unsigned H_ACT_START = 144;
    localparam int unsigned V_ACT_START = 35;
    localparam int unsigned H_ACTIVE    = 640;
    localparam int unsigned V_ACTIVE    = 480;

    // Both counters saturate here; h_cnt reaching it means hs has stopped.
    localparam logic [9:0] CNT_MAX = 10'd1023;

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        CHECK  = 2'd1,
        LOCKED = 2'd2
    } sync_state_t;

    // True when lo <= val < lo+len. Compared at 11 bits so lo+len cannot wrap.
    function automatic logic in_window(input logic [9:0] val,
                                       input logic [9:0] lo,
                                       input logic [9:0] len);
        logic [10:0] hi;
        hi = {1'b0, lo} + {1'b0, len};
        return ({1'b0, val} >= {1'b0, lo}) && ({1'b0, val} < hi);
    endfunction

endpackage

// File: rtl/vga_capture_if.sv
// Video stream in, pixel-RAM write port and lock status out.
// master = video source / RAM side, slave = the capture block.
interface vga_capture_if;
    import vga_pkg::*;

    logic        hs;
    logic        vs;
    logic [11:0] d_in;
    logic [8:0]  row_addr;
    logic [9:0]  col_addr;
    logic [11:0] d_out;
    logic        wrn;
    logic        locked;
    logic        frame_start;
    logic        sync_err;

    modport master (
        output hs, vs, d_in,
        input  row_addr, col_addr, d_out, wrn, locked, frame_start, sync_err
    );

    modport slave (
        input  hs, vs, d_in,
        output row_addr, col_addr, d_out, wrn, locked, frame_start, sync_err
    );

endinterface

// File: rtl/vga_sync_tracker.sv
// Registers the incoming sync/pixel stream, recovers h_cnt/line_cnt from the
// sync falls and runs the HUNT/CHECK/LOCKED validation state machine.
// Counters are loaded from a one-cycle look-ahead on the raw inputs so that
// they read 0 in the same cycle the registered sync is first seen low, while
// the state machine judges the period that just ended via h_last/v_last.
module vga_sync_tracker
    import vga_pkg::*;
#(
    parameter int unsigned CFG_H_TOTAL = H_TOTAL,
    parameter int unsigned CFG_V_TOTAL = V_TOTAL
)(
    input  logic        vga_clk,
    input  logic        clrn,
    input  logic        hs,
    input  logic        vs,
    input  logic [11:0] d_in,
    output logic [11:0] d_q,
    output logic [9:0]  h_cnt,
    output logic [9:0]  line_cnt,
    output sync_state_t state,
    output logic        locked,
    output logic        frame_start,
    output logic        sync_err
);

    localparam logic [9:0] H_LAST = 10'(CFG_H_TOTAL - 1);
    localparam logic [9:0] V_LAST = 10'(CFG_V_TOTAL - 1);

    logic        hs_q_r, vs_q_r;
    logic [11:0] d_q_r;
    logic        hs_fall_r, vs_fall_r;
    logic [9:0]  h_cnt_r, line_cnt_r;
    logic        h_last_r, v_last_r;
    sync_state_t state_r;
    logic        locked_r, frame_start_r, sync_err_r;
    logic        hs_fall_nx_s, vs_fall_nx_s;
    logic        timing_err_s;

    assign hs_fall_nx_s = hs_q_r & ~hs;
    assign vs_fall_nx_s = vs_q_r & ~vs;

    // Input stage and fall strobes aligned with the registered syncs.
    always_ff @(posedge vga_clk or negedge clrn) begin
        if (!clrn) begin
            hs_q_r    <= 1'b1;
            vs_q_r    <= 1'b1;
            d_q_r     <= 12'h000;
            hs_fall_r <= 1'b0;
            vs_fall_r <= 1'b0;
        end else begin
            hs_q_r    <= hs;
            vs_q_r    <= vs;
            d_q_r     <= d_in;
            hs_fall_r <= hs_fall_nx_s;
            vs_fall_r <= vs_fall_nx_s;
        end
    end

    // Pixel/line counters; vs fall wins over a coincident hs fall.
    always_ff @(posedge vga_clk or negedge clrn) begin
        if (!clrn) begin
            h_cnt_r    <= 10'd0;
            line_cnt_r <= 10'd0;
            h_last_r   <= 1'b0;
            v_last_r   <= 1'b0;
        end else begin
            if (hs_fall_nx_s) begin
                h_cnt_r <= 10'd0;
            end else if (h_cnt_r != CNT_MAX) begin
                h_cnt_r <= h_cnt_r + 10'd1;
            end
            if (vs_fall_nx_s) begin
                line_cnt_r <= 10'd0;
            end else if (hs_fall_nx_s && (line_cnt_r != CNT_MAX)) begin
                line_cnt_r <= line_cnt_r + 10'd1;
            end
            h_last_r <= (h_cnt_r == H_LAST);
            v_last_r <= (line_cnt_r == V_LAST);
        end
    end

    // Period violation seen this cycle: wrong frame at vs fall, wrong line at hs fall, or hs timeout.
    always_comb begin
        timing_err_s = 1'b0;
        if (vs_fall_r) begin
            timing_err_s = ~(v_last_r & h_last_r);
        end else if (hs_fall_r) begin
            timing_err_s = ~h_last_r;
        end else begin
            timing_err_s = (h_cnt_r == CNT_MAX);
        end
    end

    // Lock state machine with registered status pulses.
    always_ff @(posedge vga_clk or negedge clrn) begin
        if (!clrn) begin
            state_r       <= HUNT;
            locked_r      <= 1'b0;
            frame_start_r <= 1'b0;
            sync_err_r    <= 1'b0;
        end else begin
            frame_start_r <= 1'b0;
            sync_err_r    <= 1'b0;
            case (state_r)
                HUNT: begin
                    if (vs_fall_r) begin
                        state_r <= CHECK;
                    end
                end
                CHECK: begin
                    if (timing_err_s) begin
                        state_r <= HUNT;
                    end else if (vs_fall_r) begin
                        state_r       <= LOCKED;
                        locked_r      <= 1'b1;
                        frame_start_r <= 1'b1;
                    end
                end
                LOCKED: begin
                    if (timing_err_s) begin
                        state_r    <= HUNT;
                        locked_r   <= 1'b0;
                        sync_err_r <= 1'b1;
                    end else if (vs_fall_r) begin
                        frame_start_r <= 1'b1;
                    end
                end
                default: begin
                    state_r  <= HUNT;
                    locked_r <= 1'b0;
                end
            endcase
        end
    end

    assign d_q         = d_q_r;
    assign h_cnt       = h_cnt_r;
    assign line_cnt    = line_cnt_r;
    assign state       = state_r;
    assign locked      = locked_r;
    assign frame_start = frame_start_r;
    assign sync_err    = sync_err_r;

endmodule

// File: rtl/vga_capture.sv
// VGA capture top: decodes the active region from the recovered counters
// and drives the pixel-RAM write port once the sync tracker is locked.
module vga_capture
    import vga_pkg::*;
#(
    parameter int unsigned CFG_H_TOTAL     = H_TOTAL,
    parameter int unsigned CFG_V_TOTAL     = V_TOTAL,
    parameter int unsigned CFG_H_ACT_START = H_ACT_START,
    parameter int unsigned CFG_V_ACT_START = V_ACT_START,
    parameter int unsigned CFG_H_ACTIVE    = H_ACTIVE,
    parameter int unsigned CFG_V_ACTIVE    = V_ACTIVE
)(
    input  logic          vga_clk,
    input  logic          clrn,
    vga_capture_if.slave  bus
);

    logic [11:0] d_q_s;
    logic [9:0]  h_cnt_s, line_cnt_s;
    sync_state_t state_s;
    logic        locked_s, frame_start_s, sync_err_s;
    logic        active_s;
    logic [9:0]  col_s;
    logic [8:0]  row_s;
    logic [8:0]  row_addr_r;
    logic [9:0]  col_addr_r;
    logic [11:0] d_out_r;
    logic        wrn_r;

    vga_sync_tracker #(
        .CFG_H_TOTAL (CFG_H_TOTAL),
        .CFG_V_TOTAL (CFG_V_TOTAL)
    ) u_tracker (
        .vga_clk     (vga_clk),
        .clrn        (clrn),
        .hs          (bus.hs),
        .vs          (bus.vs),
        .d_in        (bus.d_in),
        .d_q         (d_q_s),
        .h_cnt       (h_cnt_s),
        .line_cnt    (line_cnt_s),
        .state       (state_s),
        .locked      (locked_s),
        .frame_start (frame_start_s),
        .sync_err    (sync_err_s)
    );

    // Active-region decode and pixel coordinates for the current d_q.
    always_comb begin
        active_s = in_window(h_cnt_s, 10'(CFG_H_ACT_START), 10'(CFG_H_ACTIVE)) &&
                   in_window(line_cnt_s, 10'(CFG_V_ACT_START), 10'(CFG_V_ACTIVE));
        col_s    = h_cnt_s - 10'(CFG_H_ACT_START);
        row_s    = 9'(line_cnt_s - 10'(CFG_V_ACT_START));
    end

    // Write-port registers: strobe low only for active pixels while locked.
    always_ff @(posedge vga_clk or negedge clrn) begin
        if (!clrn) begin
            row_addr_r <= 9'd0;
            col_addr_r <= 10'd0;
            d_out_r    <= 12'h000;
            wrn_r      <= 1'b1;
        end else if ((state_s == LOCKED) && active_s) begin
            row_addr_r <= row_s;
            col_addr_r <= col_s;
            d_out_r    <= d_q_s;
            wrn_r      <= 1'b0;
        end else begin
            wrn_r      <= 1'b1;
        end
    end

    assign bus.row_addr    = row_addr_r;
    assign bus.col_addr    = col_addr_r;
    assign bus.d_out       = d_out_r;
    assign bus.wrn         = wrn_r;
    assign bus.locked      = locked_s;
    assign bus.frame_start = frame_start_s;
    assign bus.sync_err    = sync_err_s;

endmodule

// File: tb/tb_vga_capture.sv
// Self-checking bench for vga_capture using a reduced raster so whole frames
// fit in a short run. Expected writes are queued as pixels are driven and
// popped whenever the DUT strobes wrn low.
module tb_vga_capture;

    localparam int HT  = 260;
    localparam int VT  = 14;
    localparam int HAS = 20;
    localparam int VAS = 2;
    localparam int HA  = 220;
    localparam int VA  = 10;
    localparam int HSW = 20;
    localparam int VSW = 2;

    logic vga_clk = 1'b0;
    logic clrn;

    vga_capture_if bus();

    vga_capture #(
        .CFG_H_TOTAL     (HT),
        .CFG_V_TOTAL     (VT),
        .CFG_H_ACT_START (HAS),
        .CFG_V_ACT_START (VAS),
        .CFG_H_ACTIVE    (HA),
        .CFG_V_ACTIVE    (VA)
    ) dut (
        .vga_clk (vga_clk),
        .clrn    (clrn),
        .bus     (bus)
    );

    always #20 vga_clk = ~vga_clk;

    int n_checks = 0;
    int n_fail   = 0;
    logic [30:0] sb_q[$];
    int cyc = 0;
    int frame_cyc, line_cyc, bad_line_cyc, after_bad_cyc, cur_y;
    int frame_writes, first_y;
    bit got_first;
    logic [8:0]  first_row, last_row;
    logic [9:0]  first_col, last_col;
    logic [11:0] first_d, seen_5_200;
    int fs_count = 0, fs_cyc = -1, err_count = 0, err_cyc = -1, rise_cyc = -1;
    logic prev_locked = 1'b0;

    function automatic bit is_act(input int x, input int y);
        return (x >= HAS) && (x < HAS + HA) && (y >= VAS) && (y < VAS + VA);
    endfunction

    function automatic logic [11:0] pix(input int x, input int y);
        if (is_act(x, y)) return {4'(y - VAS), 8'(x - HAS)};
        else return 12'hFFF;
    endfunction

    // One clock: sample outputs after the edge, score writes, then drive inputs.
    task automatic drive_cycle(input logic h, input logic v, input logic [11:0] d,
                               input bit push, input logic [30:0] exp_w);
        logic [30:0] got;
        logic [30:0] want;
        @(posedge vga_clk);
        #1;
        cyc++;
        if (bus.wrn === 1'b0) begin
            got = {bus.row_addr, bus.col_addr, bus.d_out};
            frame_writes++;
            if (!got_first) begin
                got_first = 1'b1;
                first_row = bus.row_addr;
                first_col = bus.col_addr;
                first_d   = bus.d_out;
                first_y   = cur_y;
            end
            last_row = bus.row_addr;
            last_col = bus.col_addr;
            if (bus.row_addr == 9'd5 && bus.col_addr == 10'd200) seen_5_200 = bus.d_out;
            n_checks++;
            if (sb_q.size() == 0) begin
                n_fail++;
                $display("FAIL write_unexpected: got row=%0d col=%0d d=%h, required no write (cyc %0d)",
                         bus.row_addr, bus.col_addr, bus.d_out, cyc);
            end else begin
                want = sb_q.pop_front();
                if (got !== want) begin
                    n_fail++;
                    $display("FAIL write_data: got row=%0d col=%0d d=%h, required row=%0d col=%0d d=%h",
                             got[30:22], got[21:12], got[11:0], want[30:22], want[21:12], want[11:0]);
                end
            end
        end
        if (bus.frame_start === 1'b1) begin fs_count++; fs_cyc = cyc; end
        if (bus.sync_err === 1'b1) begin err_count++; err_cyc = cyc; end
        if (bus.locked === 1'b1 && prev_locked !== 1'b1) rise_cyc = cyc;
        prev_locked = bus.locked;
        bus.hs   = h;
        bus.vs   = v;
        bus.d_in = d;
        if (push) sb_q.push_back(exp_w);
    endtask

    task automatic drive_line(input int y, input int len, input bit cap);
        cur_y = y;
        for (int x = 0; x < len; x++) begin
            drive_cycle((x < HSW) ? 1'b0 : 1'b1, (y < VSW) ? 1'b0 : 1'b1, pix(x, y),
                        cap && is_act(x, y), {9'(y - VAS), 10'(x - HAS), pix(x, y)});
            if (x == 0) begin
                line_cyc = cyc;
                if (y == 0) frame_cyc = cyc;
            end
        end
    endtask

    // Frame of n_lines; line bad_y gets length bad_len; capture stops after bad_y.
    task automatic drive_frame(input int n_lines, input int bad_y, input int bad_len, input bit cap);
        frame_writes = 0;
        got_first    = 1'b0;
        seen_5_200   = 12'hxxx;
        for (int y = 0; y < n_lines; y++) begin
            drive_line(y, (y == bad_y) ? bad_len : HT, cap && ((bad_y < 0) || (y <= bad_y)));
            if (y == bad_y) bad_line_cyc = line_cyc;
            if (bad_y >= 0 && y == bad_y + 1) after_bad_cyc = line_cyc;
        end
    endtask

    task automatic test_reset;
        clrn = 1'b0;
        bus.hs = 1'b1; bus.vs = 1'b1; bus.d_in = 12'h000;
        for (int i = 0; i < 6; i++) drive_cycle(1'(i % 2), 1'(i / 3), 12'hA5A, 1'b0, 31'd0);
        n_checks++;
        if ({bus.wrn, bus.locked, bus.frame_start, bus.sync_err} !== 4'b1000) begin
            n_fail++;
            $display("FAIL reset_status: got wrn/locked/fs/err=%b, required 1000",
                     {bus.wrn, bus.locked, bus.frame_start, bus.sync_err});
        end
        n_checks++;
        if ({bus.row_addr, bus.col_addr, bus.d_out} !== 31'd0) begin
            n_fail++;
            $display("FAIL reset_bus: got row=%0d col=%0d d=%h, required 0/0/000",
                     bus.row_addr, bus.col_addr, bus.d_out);
        end
        clrn = 1'b1;
        for (int i = 0; i < 8; i++) drive_cycle(1'b1, 1'b1, 12'h000, 1'b0, 31'd0);
    endtask

    task automatic test_clean;
        drive_frame(VT, -1, 0, 1'b0);
        n_checks++;
        if (prev_locked !== 1'b0 || frame_writes != 0) begin
            n_fail++;
            $display("FAIL clean_first_frame: got locked=%b writes=%0d, required 0/0", prev_locked, frame_writes);
        end
        rise_cyc = -1;
        drive_frame(VT, -1, 0, 1'b1);
        n_checks++;
        if (rise_cyc != frame_cyc + 2) begin
            n_fail++;
            $display("FAIL clean_lock_time: got cyc %0d, required %0d", rise_cyc, frame_cyc + 2);
        end
        n_checks++;
        if ({first_row, first_col, first_d} !== 31'd0) begin
            n_fail++;
            $display("FAIL clean_first_write: got row=%0d col=%0d d=%h, required 0/0/000", first_row, first_col, first_d);
        end
        n_checks++;
        if (seen_5_200 !== 12'h5C8) begin
            n_fail++;
            $display("FAIL clean_pix_5_200: got %h, required 5c8", seen_5_200);
        end
        n_checks++;
        if (frame_writes != HA * VA || last_row !== 9'(VA - 1) || last_col !== 10'(HA - 1)) begin
            n_fail++;
            $display("FAIL clean_frame_count: got %0d writes last %0d/%0d, required %0d last %0d/%0d",
                     frame_writes, last_row, last_col, HA * VA, VA - 1, HA - 1);
        end
        n_checks++;
        if (sb_q.size() != 0 || err_count != 0) begin
            n_fail++;
            $display("FAIL clean_residue: got queue=%0d err=%0d, required 0/0", sb_q.size(), err_count);
        end
    endtask

    task automatic test_coincident;
        int fs0;
        fs0 = fs_count;
        drive_frame(VT, -1, 0, 1'b1);
        n_checks++;
        if (fs_count - fs0 != 1 || fs_cyc != frame_cyc + 2) begin
            n_fail++;
            $display("FAIL coinc_frame_start: got %0d pulses at %0d, required 1 at %0d",
                     fs_count - fs0, fs_cyc, frame_cyc + 2);
        end
        n_checks++;
        if (first_y != VAS || first_row !== 9'd0 || frame_writes != HA * VA) begin
            n_fail++;
            $display("FAIL coinc_row0_line: got line %0d row %0d writes %0d, required line %0d row 0 writes %0d",
                     first_y, first_row, frame_writes, VAS, HA * VA);
        end
    endtask

    // Violating frame, one frame to revalidate, then a captured frame.
    task automatic recover_and_check(input string name);
        drive_frame(VT, -1, 0, 1'b0);
        n_checks++;
        if (prev_locked !== 1'b0 || frame_writes != 0) begin
            n_fail++;
            $display("FAIL %s_check_frame: got locked=%b writes=%0d, required 0/0", name, prev_locked, frame_writes);
        end
        rise_cyc = -1;
        drive_frame(VT, -1, 0, 1'b1);
        n_checks++;
        if (rise_cyc != frame_cyc + 2 || frame_writes != HA * VA || sb_q.size() != 0) begin
            n_fail++;
            $display("FAIL %s_relock: got rise %0d writes %0d queue %0d, required rise %0d writes %0d queue 0",
                     name, rise_cyc, frame_writes, sb_q.size(), frame_cyc + 2, HA * VA);
        end
    endtask

    task automatic test_short_line;
        int e0;
        e0 = err_count;
        drive_frame(VT, 5, 200, 1'b1);
        n_checks++;
        if (err_count - e0 != 1 || err_cyc != after_bad_cyc + 2 || prev_locked !== 1'b0) begin
            n_fail++;
            $display("FAIL short_sync_err: got %0d pulses at %0d locked=%b, required 1 at %0d locked=0",
                     err_count - e0, err_cyc, prev_locked, after_bad_cyc + 2);
        end
        recover_and_check("short");
    endtask

    task automatic test_stuck_hs;
        int e0;
        e0 = err_count;
        drive_frame(VT, 4, 1100, 1'b1);
        n_checks++;
        if (err_count - e0 != 1 || err_cyc != bad_line_cyc + 1025 || prev_locked !== 1'b0) begin
            n_fail++;
            $display("FAIL stuck_timeout: got %0d pulses at %0d locked=%b, required 1 at %0d locked=0",
                     err_count - e0, err_cyc, prev_locked, bad_line_cyc + 1025);
        end
        recover_and_check("stuck");
    endtask

    task automatic test_wrong_len;
        int e0;
        e0 = err_count;
        drive_frame(VT - 1, -1, 0, 1'b1);
        n_checks++;
        if (err_count != e0 || frame_writes != HA * VA) begin
            n_fail++;
            $display("FAIL wronglen_early: got err %0d writes %0d, required 0/%0d", err_count - e0, frame_writes, HA * VA);
        end
        drive_frame(VT, -1, 0, 1'b0);
        n_checks++;
        if (err_count - e0 != 1 || err_cyc != frame_cyc + 2 || prev_locked !== 1'b0) begin
            n_fail++;
            $display("FAIL wronglen_sync_err: got %0d pulses at %0d locked=%b, required 1 at %0d locked=0",
                     err_count - e0, err_cyc, prev_locked, frame_cyc + 2);
        end
        recover_and_check("wronglen");
    endtask

    task automatic test_reset_midstream;
        for (int y = 0; y < 5; y++) drive_line(y, HT, 1'b1);
        cur_y = 5;
        for (int x = 0; x < 100; x++)
            drive_cycle((x < HSW) ? 1'b0 : 1'b1, 1'b1, pix(x, 5), is_act(x, 5),
                        {9'(5 - VAS), 10'(x - HAS), pix(x, 5)});
        #4 clrn = 1'b0;
        #1;
        n_checks++;
        if ({bus.wrn, bus.locked, bus.row_addr, bus.col_addr, bus.d_out} !== {2'b10, 31'd0}) begin
            n_fail++;
            $display("FAIL midreset_async: got wrn=%b locked=%b row=%0d col=%0d d=%h, required 1/0/0/0/000",
                     bus.wrn, bus.locked, bus.row_addr, bus.col_addr, bus.d_out);
        end
        sb_q.delete();
        for (int x = 100; x < HT; x++) begin
            if (x == 105) clrn = 1'b1;
            drive_cycle((x < HSW) ? 1'b0 : 1'b1, 1'b1, pix(x, 5), 1'b0, 31'd0);
        end
        for (int y = 6; y < VT; y++) drive_line(y, HT, 1'b0);
        recover_and_check("midreset");
    endtask

    initial begin
        test_reset();
        test_clean();
        test_coincident();
        test_short_line();
        test_stuck_hs();
        test_wrong_len();
        test_reset_midstream();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/vga_capture.md
Name: vga_capture

Overview:
- Receive-side counterpart of the VGA timing controller: samples an incoming hs/vs/12-bit pixel stream on vga_clk and recovers pixel coordinates from the sync edges.
- Writes each active pixel into pixel RAM through an active-low write strobe with row/col addresses.
- Runs a lock state machine that validates line and frame periods before any write is issued.
- Sits between a VGA source (test pattern or loopback of the display path) and the frame-buffer write port.

Parameters:
- H_TOTAL, 800, clocks per line (hs fall to hs fall)
- V_TOTAL, 525, lines per frame (vs fall to vs fall)
- H_ACT_START, 144, h_cnt value of first active pixel (h_cnt=0 on first cycle registered hs is low)
- V_ACT_START, 35, line_cnt value of first active line (line_cnt=0 on line where registered vs falls)
- H_ACTIVE, 640, active pixels per line
- V_ACTIVE, 480, active lines per frame

Ports:
- vga_clk  in  1  pixel clock, 25 MHz
- clrn  in  1  asynchronous active-low reset
- hs  in  1  horizontal sync, active low
- vs  in  1  vertical sync, active low
- d_in  in  12  pixel bbbb_gggg_rrrr
- row_addr  out  9  pixel RAM row address, 0..479
- col_addr  out  10  pixel RAM col address, 0..639
- d_out  out  12  pixel to write
- wrn  out  1  pixel RAM write strobe, active low
- locked  out  1  timing validated, writes enabled
- frame_start  out  1  one-cycle pulse at vs fall while locked
- sync_err  out  1  one-cycle pulse when timing violated while locked

Behaviour:
- Reset (clrn=0, async): all registers clear. wrn=1, row_addr=0, col_addr=0, d_out=0, locked=0, frame_start=0, sync_err=0, FSM=HUNT, counters=0, input regs hs_q=1, vs_q=1.
- Input stage: hs, vs and d_in are registered once (hs_q, vs_q, d_q). An edge is a fall when the previous hs_q/vs_q was 1 and the current one is 0.
- h_cnt (10 bit):
  - 0 on the cycle of an hs fall; otherwise increments.
  - Saturates at 1023; reaching 1023 is a timeout.
- line_cnt (10 bit):
  - 0 on a vs fall.
  - Otherwise increments on each hs fall; saturates at 1023.
  - vs and hs may fall in the same cycle; vs takes priority, so line_cnt=0.
- Active region:
  - h_cnt in [H_ACT_START, H_ACT_START+H_ACTIVE-1] and line_cnt in [V_ACT_START, V_ACT_START+V_ACTIVE-1].
  - col = h_cnt-H_ACT_START; row = line_cnt-V_ACT_START, truncated to 9 bits.
- FSM states HUNT, CHECK, LOCKED:
  - HUNT: wait for vs fall, then go to CHECK.
  - CHECK: at each hs fall that is not a vs fall, require h_cnt==H_TOTAL-1, else go to HUNT.
    - Timeout also sends CHECK to HUNT.
    - At the next vs fall, if line_cnt==V_TOTAL-1 and h_cnt==H_TOTAL-1, go to LOCKED; otherwise go to HUNT.
  - LOCKED: apply the same checks as CHECK, at every hs and vs fall. Any violation sends the FSM to HUNT and pulses sync_err for 1 cycle, registered with the transition.
  - No sync_err in HUNT/CHECK.
- locked=1 exactly when state==LOCKED, registered.
- Writes:
  - Issued only in LOCKED and in the active region.
  - Output registers load row_addr<=row, col_addr<=col, d_out<=d_q, wrn<=0.
  - Outside the active region or when not LOCKED, wrn<=1 and addr/data hold their last value.
- Latency: a pixel presented on d_in at cycle t appears on d_out with wrn=0 at cycle t+2.
- The first frame written is the frame that begins at the vs fall causing CHECK->LOCKED.
- frame_start pulses the cycle after a vs fall that occurs in LOCKED, or the fall that enters LOCKED.
- A violation detected mid-line forces wrn=1 from the next cycle. No partial-line cleanup.
- The write count per clean frame is exactly H_ACTIVE*V_ACTIVE = 307200.

Decomposition:
- Package vga_pkg:
  - Timing constants H_TOTAL, V_TOTAL, H_ACT_START, V_ACT_START, H_ACTIVE, V_ACTIVE, shared with the display controller.
  - State encoding HUNT=2'd0, CHECK=2'd1, LOCKED=2'd2.
- Sub-module vga_sync_tracker: input registers, edge detect, h_cnt/line_cnt, FSM; outputs state, counters and edge strobes.
- The vga_capture top holds the active-region decode and output registers.

Test Plan:
- Reset: assert clrn=0 mid-stream with hs/vs toggling -> wrn=1, locked=0, addrs=0, d_out=0 immediately. After release, no write until a full valid frame has passed.
- Clean timing:
  - Drive 800x525 timing with d_in={row[3:0],col[7:0]}.
  - locked rises 1 cycle after the 2nd vs fall.
  - First wrn=0 is row 0/col 0 with d_out=12'h000.
  - Write at row 5/col 200 carries 12'h5C8.
  - 307200 writes per frame, last at row 479/col 639.
- Short line: while locked, hs falls at h_cnt=700 -> sync_err high 1 cycle, locked=0, no writes until 2 full clean frames (HUNT->CHECK->LOCKED).
- Stuck hs: hold hs=1 while locked -> at h_cnt=1023, sync_err pulse, locked=0, wrn stays 1.
- Wrong frame length: send a 524-line frame while locked -> sync_err at that vs fall, relock after one clean frame.
- Coincident edges: hs and vs fall in the same cycle -> line_cnt=0, not 1. frame_start pulses once. Row 0 first written at line V_ACT_START.
